mux3_rr_sel: RTL and testbench

- Upstream select generator for the 3:1 single-bit mux stage.
- Arbitrates three channel requests round-robin and holds each grant for a programmable dwell time.
- Drives the mux select pair {sel1,sel2} with only the legal codes 00, 01 and 10; code 11 is never produced.
- Also outputs a one-hot grant and a valid flag so that sources know when their bit is being forwarded.

---
 rtl/mux3_rr_sel.sv | 201 ++++++++++++++++++++
 tb/tb_mux3_rr_sel.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mux3_rr_sel.sv
// ---------------------------------------------------------------------------
// mux3_rr_sel
//   Select generator for a 3:1 single-bit mux stage. Three channel requests
//   are arbitrated round-robin, and each grant is held for DWELL cycles or
//   until the granted channel drops its request, whichever comes first.
//   The mux select pair only ever carries 00, 01 or 10.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   en         enables starting new grants (never aborts a running slot)
//   req[2:0]   per-channel request, bit0 = a, bit1 = b, bit2 = c
//   sel1       mux select MSB (registered)
//   sel2       mux select LSB (registered)
//   gnt[2:0]   one-hot grant (registered)
//   gnt_valid  high while a grant is active (registered)
//   slot_done  high in the final cycle of a slot (combinational from state)
// ---------------------------------------------------------------------------
module mux3_rr_sel #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned CW    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [2:0] req,
  output logic       sel1,
  output logic       sel2,
  output logic [2:0] gnt,
  output logic       gnt_valid,
  output logic       slot_done
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  localparam logic [CW-1:0] CNT_RELOAD = CW'(DWELL - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Channel that follows ch in the rotation 0 -> 1 -> 2 -> 0.
  function automatic logic [1:0] next_ch(input logic [1:0] ch);
    logic [1:0] n;
    case (ch)
      2'd0:    n = 2'd1;
      2'd1:    n = 2'd2;
      default: n = 2'd0;
    endcase
    return n;
  endfunction

  // First requesting channel searching start, start+1, start+2 (mod 3).
  // Only meaningful when at least one request bit is set.
  function automatic logic [1:0] rr_pick(input logic [1:0] start,
                                         input logic [2:0] r);
    logic [1:0] p;
    case (start)
      2'd0: begin
        if (r[0])      p = 2'd0;
        else if (r[1]) p = 2'd1;
        else           p = 2'd2;
      end
      2'd1: begin
        if (r[1])      p = 2'd1;
        else if (r[2]) p = 2'd2;
        else           p = 2'd0;
      end
      default: begin
        if (r[2])      p = 2'd2;
        else if (r[0]) p = 2'd0;
        else           p = 2'd1;
      end
    endcase
    return p;
  endfunction

  // One-hot grant vector for a channel index.
  function automatic logic [2:0] onehot(input logic [1:0] ch);
    logic [2:0] o;
    case (ch)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      2'd2:    o = 3'b100;
      default: o = 3'b000;
    endcase
    return o;
  endfunction

  state_t        state_q, state_d;
  logic [1:0]    ptr_q,   ptr_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [2:0]    gnt_q,   gnt_d;
  logic          valid_q, valid_d;
  logic [1:0]    sel_q,   sel_d;

  logic          req_g_s;
  logic          end_s;
  logic          any_req_s;
  logic [1:0]    win_s;

  // Request of the currently granted channel. The select code doubles as the
  // channel index because the encoding is ch0 -> 00, ch1 -> 01, ch2 -> 10.
  always_comb begin
    case (sel_q)
      2'd0:    req_g_s = req[0];
      2'd1:    req_g_s = req[1];
      default: req_g_s = req[2];
    endcase
  end

  assign any_req_s = |req;
  assign end_s     = (cnt_q == '0) || !req_g_s;
  assign slot_done = (state_q == S_GRANT) && end_s;

  // Search origin: pointer from IDLE, the channel after the current one when
  // a slot ends. Both equal the value ptr will hold after this cycle.
  always_comb begin
    if (state_q == S_GRANT) begin
      win_s = rr_pick(next_ch(sel_q), req);
    end else begin
      win_s = rr_pick(ptr_q, req);
    end
  end

  // Next-state and output-register logic; everything holds by default.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (en && any_req_s) begin
          state_d = S_GRANT;
          gnt_d   = onehot(win_s);
          sel_d   = win_s;
          valid_d = 1'b1;
          cnt_d   = CNT_RELOAD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_GRANT: begin
        if (end_s) begin
          ptr_d = next_ch(sel_q);
          if (en && any_req_s) begin
            // Back-to-back grant with no idle bubble; may re-grant sel_q.
            state_d = S_GRANT;
            gnt_d   = onehot(win_s);
            sel_d   = win_s;
            valid_d = 1'b1;
            cnt_d   = CNT_RELOAD;
          end else begin
            // sel keeps its last code so the mux input does not glitch.
            state_d = S_IDLE;
            gnt_d   = 3'b000;
            valid_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ptr_d   = 2'd0;
        cnt_d   = '0;
        gnt_d   = 3'b000;
        valid_d = 1'b0;
        sel_d   = 2'd0;
      end
    endcase
  end

  // State, pointer, counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      cnt_q   <= '0;
      gnt_q   <= 3'b000;
      valid_q <= 1'b0;
      sel_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
    end
  end

  assign sel1      = sel_q[1];
  assign sel2      = sel_q[0];
  assign gnt       = gnt_q;
  assign gnt_valid = valid_q;

endmodule

// File: tb/tb_mux3_rr_sel.sv
// ---------------------------------------------------------------------------
// tb_mux3_rr_sel
//   Directed bench for mux3_rr_sel. Two instances share the inputs: u4 with
//   DWELL=4 and u1 with DWELL=1. A vector table exercises u4 through single
//   requester, all-requesting, early drop and enable gating. Hand sequences
//   cover the DWELL=1 rotation, grant order after reset and an asynchronous
//   mid-slot reset, followed by random stimulus with invariant checks.
// ---------------------------------------------------------------------------
module tb_mux3_rr_sel;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [2:0] req;

  logic       sel1_4, sel2_4, valid_4, done_4;
  logic [2:0] gnt_4;
  logic       sel1_1, sel2_1, valid_1, done_1;
  logic [2:0] gnt_1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux3_rr_sel #(.DWELL(4), .CW(8)) u4 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel1(sel1_4), .sel2(sel2_4), .gnt(gnt_4),
    .gnt_valid(valid_4), .slot_done(done_4)
  );

  mux3_rr_sel #(.DWELL(1), .CW(8)) u1 (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req),
    .sel1(sel1_1), .sel2(sel2_1), .gnt(gnt_1),
    .gnt_valid(valid_1), .slot_done(done_1)
  );

  typedef struct {
    logic       en;
    logic [2:0] req;
    logic [2:0] gnt;
    logic [1:0] sel;
    logic       valid;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic e, input logic [2:0] r,
                              input logic [2:0] g, input logic [1:0] s,
                              input logic v, input logic d);
    vec_t x;
    x.en = e; x.req = r; x.gnt = g; x.sel = s; x.valid = v; x.done = d;
    return x;
  endfunction

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b required %b ({gnt,sel,valid,done})",
               name, act[6:0], exp[6:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] obs4();
    return {1'b0, gnt_4, sel1_4, sel2_4, valid_4, done_4};
  endfunction

  function automatic logic [7:0] obs1();
    return {1'b0, gnt_1, sel1_1, sel2_1, valid_1, done_1};
  endfunction

  function automatic logic inv_ok(input logic [2:0] g, input logic [1:0] s,
                                  input logic v);
    logic [2:0] sg;
    sg = 3'b001 << s;
    return ($countones(g) <= 1) && (v == (|g)) && (s != 2'b11) &&
           (!v || (g == sg));
  endfunction

  initial begin
    logic [2:0] eg;
    logic [1:0] es;
    logic       ed;
    int         k;

    // Table for the DWELL=4 instance, starting from reset (ptr=0).
    // Each row: inputs applied after an edge, outputs expected before the next.
    tbl.push_back(mk(1'b1, 3'b000, 3'b000, 2'b00, 1'b0, 1'b0)); // idle
    tbl.push_back(mk(1'b1, 3'b010, 3'b000, 2'b00, 1'b0, 1'b0)); // req sampled
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0)); // 1-cycle lat
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b1)); // 4th cycle
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0)); // self regrant
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b010, 3'b010, 2'b01, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b000, 3'b010, 2'b01, 1'b1, 1'b1)); // end, no req
    tbl.push_back(mk(1'b1, 3'b000, 3'b000, 2'b01, 1'b0, 1'b0)); // sel holds
    tbl.push_back(mk(1'b1, 3'b111, 3'b000, 2'b01, 1'b0, 1'b0)); // ptr=2
    tbl.push_back(mk(1'b1, 3'b111, 3'b100, 2'b10, 1'b1, 1'b0)); // ch2 first
    tbl.push_back(mk(1'b1, 3'b111, 3'b100, 2'b10, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b111, 3'b100, 2'b10, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b111, 3'b100, 2'b10, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 3'b111, 3'b001, 2'b00, 1'b1, 1'b0)); // ch0
    tbl.push_back(mk(1'b1, 3'b111, 3'b001, 2'b00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b111, 3'b001, 2'b00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b111, 3'b001, 2'b00, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 3'b111, 3'b010, 2'b01, 1'b1, 1'b0)); // ch1 cyc 1
    tbl.push_back(mk(1'b1, 3'b101, 3'b010, 2'b01, 1'b1, 1'b1)); // early drop
    tbl.push_back(mk(1'b1, 3'b101, 3'b100, 2'b10, 1'b1, 1'b0)); // ch2 no gap
    tbl.push_back(mk(1'b1, 3'b101, 3'b100, 2'b10, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b101, 3'b100, 2'b10, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 3'b101, 3'b100, 2'b10, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 3'b101, 3'b001, 2'b00, 1'b1, 1'b0)); // ch0 slot
    tbl.push_back(mk(1'b0, 3'b101, 3'b001, 2'b00, 1'b1, 1'b0)); // en drops
    tbl.push_back(mk(1'b0, 3'b101, 3'b001, 2'b00, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 3'b101, 3'b001, 2'b00, 1'b1, 1'b1)); // full dwell
    tbl.push_back(mk(1'b0, 3'b101, 3'b000, 2'b00, 1'b0, 1'b0)); // idle
    tbl.push_back(mk(1'b1, 3'b101, 3'b000, 2'b00, 1'b0, 1'b0)); // en back
    tbl.push_back(mk(1'b1, 3'b101, 3'b100, 2'b10, 1'b1, 1'b0)); // ch2 (ptr=1)
    tbl.push_back(mk(1'b1, 3'b000, 3'b100, 2'b10, 1'b1, 1'b1)); // drop, none
    tbl.push_back(mk(1'b1, 3'b000, 3'b000, 2'b10, 1'b0, 1'b0)); // valid low

    rst_n = 1'b0;
    en    = 1'b0;
    req   = 3'b000;
    #12;
    chk("reset_u4", obs4(), 8'h00);
    chk("reset_u1", obs1(), 8'h00);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      tick();
      en  = tbl[i].en;
      req = tbl[i].req;
      #1;
      chk($sformatf("tbl[%0d]", i), obs4(),
          {1'b0, tbl[i].gnt, tbl[i].sel, tbl[i].valid, tbl[i].done});
    end

    // Fresh start from reset with all channels requesting.
    tick();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 3'b111;
    #2;
    rst_n = 1'b1;
    #1;
    chk("rr_s0_u4", obs4(), 8'h00);
    chk("rr_s0_u1", obs1(), 8'h00);
    for (int s = 1; s <= 9; s++) begin
      tick();
      #1;
      // DWELL=4: ch0 for 4 cycles, then ch1, then ch2.
      k  = ((s - 1) / 4) % 3;
      eg = 3'b001 << k;
      es = 2'(k);
      ed = (s % 4) == 0;
      chk($sformatf("rr4_s%0d", s), obs4(), {1'b0, eg, es, 1'b1, ed});
      // DWELL=1: rotates every cycle, slot_done stays high.
      k  = (s - 1) % 3;
      eg = 3'b001 << k;
      es = 2'(k);
      chk($sformatf("rr1_s%0d", s), obs1(), {1'b0, eg, es, 1'b1, 1'b1});
    end

    // u4 is now granting ch2; reset asynchronously away from any edge.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_u4", obs4(), 8'h00);
    chk("async_rst_u1", obs1(), 8'h00);
    req = 3'b000;
    #2;
    rst_n = 1'b1;
    for (int s = 0; s < 2; s++) begin
      tick();
      #1;
      chk($sformatf("post_rst_u4_%0d", s), obs4(), 8'h00);
      chk($sformatf("post_rst_u1_%0d", s), obs1(), 8'h00);
    end

    // Random traffic: structural invariants on both instances.
    for (int c = 0; c < 10000; c++) begin
      tick();
      en  = 1'($urandom_range(0, 3) != 0);
      req = 3'($urandom);
      #1;
      chk("inv_u4", {7'd0, inv_ok(gnt_4, {sel1_4, sel2_4}, valid_4)}, 8'h01);
      chk("inv_u1", {7'd0, inv_ok(gnt_1, {sel1_1, sel2_1}, valid_1)}, 8'h01);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
